// File: rtl/ppm_pkg.sv
// Shared types and constants for the 1-of-4 PPM receive controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ppm_pkg;

   // Frame controller states; busy is derived from ST_RUN only.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam int SLOTS_PER_SYM = 4;
   localparam int SYMS_PER_BYTE = 4;

   // One PPM symbol carries two data bits (the index of the pulsed slot).
   typedef logic [1:0] sym_t;

endpackage

// File: rtl/ppm_rx_ctrl_if.sv
// Decoded-byte output stream plus frame status flags of the PPM receiver.
// Latency: n/a (wiring only).
// Backpressure: byte is held while data_valid is high and out_ready is low.
// Ports: data_out/data_valid/out_ready byte handshake; busy, frame_done,
//        frame_err status. master = receiver, slave = downstream consumer.
interface ppm_rx_ctrl_if;
   logic [7:0] data_out;
   logic       data_valid;
   logic       out_ready;
   logic       busy;
   logic       frame_done;
   logic       frame_err;

   modport master (
      output data_out, data_valid, busy, frame_done, frame_err,
      input  out_ready
   );

   modport slave (
      input  data_out, data_valid, busy, frame_done, frame_err,
      output out_ready
   );
endinterface

// File: rtl/ppm_slot_timer.sv
// PPM slot timing: slot counter, slot index, mid-slot sample and end-of-symbol strobes.
// Latency: strobes are combinational from the counters; counters start at 0 on the first run cycle.
// Backpressure: none; counters are held at zero whenever run is low.
// Ports: clk16/rst clock and sync reset; run enables counting; slot_cnt, slot_idx,
//        sample_stb (slot_cnt == SLOT_CLKS/2), sym_end_stb (last cycle of slot 3).
module ppm_slot_timer
   import ppm_pkg::*;
#(
   parameter int SLOT_CLKS = 16
) (
   input  logic                         clk16,
   input  logic                         rst,
   input  logic                         run,
   output logic [$clog2(SLOT_CLKS)-1:0] slot_cnt,
   output sym_t                         slot_idx,
   output logic                         sample_stb,
   output logic                         sym_end_stb
);
   localparam int CW = $clog2(SLOT_CLKS);

   localparam logic [CW-1:0] CNT_HALF = CW'(SLOT_CLKS / 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CLKS - 1);
   localparam sym_t          IDX_LAST = sym_t'(SLOTS_PER_SYM - 1);

   always_ff @(posedge clk16) begin
      if (rst || !run) begin
         slot_cnt <= '0;
         slot_idx <= '0;
      end else if (slot_cnt == CNT_LAST) begin
         slot_cnt <= '0;
         slot_idx <= slot_idx + 2'd1;   // wraps 3 -> 0 at symbol boundary
      end else begin
         slot_cnt <= slot_cnt + CW'(1);
      end
   end

   assign sample_stb  = run && (slot_cnt == CNT_HALF);
   assign sym_end_stb = run && (slot_cnt == CNT_LAST) && (slot_idx == IDX_LAST);

endmodule

// File: rtl/ppm_rx_ctrl.sv
// 1-of-4 PPM frame decoder: samples Din per slot, builds bytes LSB pair first, flags end/errors.
// Latency: byte appears on data_out the cycle after its fourth symbol is evaluated.
// Backpressure: one-byte holding register; a new byte while the old one is untaken aborts the frame.
// Ports: clk16, rst (sync, active-high), Din (pulse = low), sof_rcv (start pulse),
//        bus (ppm_rx_ctrl_if.master: data_out/data_valid/out_ready, busy, frame_done, frame_err).
// Config: define PPM_RX_MAXLEN_EN to limit frames to MAX_BYTES payload bytes.
module ppm_rx_ctrl
   import ppm_pkg::*;
#(
   parameter int SLOT_CLKS = 16,
   parameter int MAX_BYTES = 32
) (
   input  logic          clk16,
   input  logic          rst,
   input  logic          Din,
   input  logic          sof_rcv,
   ppm_rx_ctrl_if.master bus
);
   localparam int CW = $clog2(SLOT_CLKS);

   state_t        state;
   sym_t          sym_idx;
   sym_t          pulse_slot;
   sym_t          slot_idx;
   logic [1:0]    pulse_cnt;     // saturates at 2: "two or more" is all that matters
   logic [5:0]    byte_sr;       // symbols 0..2, symbol 0 ends up in [1:0]
   logic [CW-1:0] slot_cnt;
   logic          sample_stb;
   logic          sym_end_stb;
   logic          run;
   logic          go_done;
   logic          go_err;
   logic          load;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          unused_slot_cnt;

`ifdef PPM_RX_MAXLEN_EN
   localparam int BCW = $clog2(MAX_BYTES + 1);
   logic [BCW-1:0] byte_cnt;
`else
   logic unused_cfg;
   assign unused_cfg = (MAX_BYTES > 0);
`endif

   assign run             = (state == ST_RUN);
   assign unused_slot_cnt = ^slot_cnt;

   ppm_slot_timer #(.SLOT_CLKS(SLOT_CLKS)) u_slot_timer (
      .clk16       (clk16),
      .rst         (rst),
      .run         (run),
      .slot_cnt    (slot_cnt),
      .slot_idx    (slot_idx),
      .sample_stb  (sample_stb),
      .sym_end_stb (sym_end_stb)
   );

   // Symbol evaluation on the last cycle of slot 3.
   always_comb begin
      go_done = 1'b0;
      go_err  = 1'b0;
      load    = 1'b0;
      if (run && sym_end_stb) begin
         if (pulse_cnt == 2'd0) begin
            // Silence on a byte boundary is the end-of-frame marker.
            if (sym_idx == 2'd0) go_done = 1'b1;
            else                 go_err  = 1'b1;
         end else if (pulse_cnt != 2'd1) begin
            go_err = 1'b1;
`ifdef PPM_RX_MAXLEN_EN
         end else if (sym_idx == 2'd0 && byte_cnt >= BCW'(MAX_BYTES)) begin
            go_err = 1'b1;
`endif
         end else if (sym_idx == 2'd3) begin
            // A transfer this same cycle frees the holding register in time.
            if (valid_q && !bus.out_ready) go_err = 1'b1;
            else                           load   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk16) begin
      if (rst) begin
         state      <= ST_IDLE;
         sym_idx    <= '0;
         pulse_cnt  <= '0;
         pulse_slot <= '0;
         byte_sr    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
`ifdef PPM_RX_MAXLEN_EN
         byte_cnt   <= '0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (sof_rcv) begin
                  state     <= ST_RUN;
                  sym_idx   <= '0;
                  pulse_cnt <= '0;
`ifdef PPM_RX_MAXLEN_EN
                  byte_cnt  <= '0;
`endif
               end
            end
            ST_RUN: begin
               if (go_done)     state <= ST_DONE;
               else if (go_err) state <= ST_ERR;
               if (sample_stb && !Din && pulse_cnt != 2'd2) begin
                  pulse_cnt  <= pulse_cnt + 2'd1;
                  pulse_slot <= slot_idx;
               end
               if (sym_end_stb) begin
                  pulse_cnt <= '0;
                  sym_idx   <= sym_idx + 2'd1;
                  byte_sr   <= {pulse_slot, byte_sr[5:2]};
               end
            end
            default: state <= ST_IDLE;   // DONE / ERR last one cycle
         endcase

         if (load) begin
            data_q  <= {pulse_slot, byte_sr};
            valid_q <= 1'b1;
`ifdef PPM_RX_MAXLEN_EN
            byte_cnt <= byte_cnt + BCW'(1);
`endif
         end else if (go_err) begin
            valid_q <= 1'b0;             // an aborted frame drops any pending byte
         end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.busy       = (state == ST_RUN);
   assign bus.frame_done = (state == ST_DONE);
   assign bus.frame_err  = (state == ST_ERR);

endmodule

// File: tb/tb_ppm_rx_ctrl.sv
// Directed bench for ppm_rx_ctrl with a byte scoreboard and immediate assertions.
// Latency: n/a.
// Backpressure: out_ready driven per test step.
module tb_ppm_rx_ctrl;
   localparam int SLOT = 16;

   logic clk16 = 1'b0;
   logic rst;
   logic Din;
   logic sof_rcv;

   ppm_rx_ctrl_if bus ();

   ppm_rx_ctrl #(.SLOT_CLKS(SLOT), .MAX_BYTES(2)) dut (
      .clk16   (clk16),
      .rst     (rst),
      .Din     (Din),
      .sof_rcv (sof_rcv),
      .bus     (bus.master)
   );

   always #5 clk16 = ~clk16;

   int n_assert = 0;
   int n_fail   = 0;
   int dv_hi    = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   logic [7:0] q[$];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: sampled just after the falling edge, after stimulus updates.
   always begin
      @(negedge clk16);
      #1;
      if (bus.data_valid === 1'b1) dv_hi++;
      if (bus.frame_done === 1'b1) done_cnt++;
      if (bus.frame_err === 1'b1)  err_cnt++;
      if (bus.frame_done === 1'b1 || bus.frame_err === 1'b1)
         check("done_err_excl", {7'b0, bus.frame_done & bus.frame_err}, 8'h00);
      if (bus.data_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (q.size() == 0) check("unexpected_byte", 8'(q.size()), 8'd1);
         else               check("byte", bus.data_out, q.pop_front());
      end
   end

   task automatic start_frame();
      sof_rcv = 1'b1;
      @(negedge clk16);
      sof_rcv = 1'b0;
   endtask

   task automatic send_symbol(input logic [3:0] mask);
      for (int s = 0; s < 4; s++) begin
         Din = ~mask[s];
         repeat (SLOT) @(negedge clk16);
      end
      Din = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [1:0] v;
      logic [3:0] m;
      for (int i = 0; i < 4; i++) begin
         v = b[2*i +: 2];
         m = 4'b0001 << v;
         send_symbol(m);
      end
   endtask

   task automatic wait_evt(input int budget, output logic got_done, output logic got_err);
      got_done = 1'b0;
      got_err  = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.frame_done === 1'b1 || bus.frame_err === 1'b1) begin
            got_done = bus.frame_done;
            got_err  = bus.frame_err;
            return;
         end
         @(negedge clk16);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_data_out"}, bus.data_out, 8'h00);
      check({tag, "_valid"}, {7'b0, bus.data_valid}, 8'h00);
      check({tag, "_busy"}, {7'b0, bus.busy}, 8'h00);
      check({tag, "_done"}, {7'b0, bus.frame_done}, 8'h00);
      check({tag, "_err"}, {7'b0, bus.frame_err}, 8'h00);
   endtask

   initial begin
      logic gd, ge;
      int   dv0, err0;

      rst = 1'b1; Din = 1'b1; sof_rcv = 1'b0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk16);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk16);

      // Byte 0xB4 (slots 0,1,3,2) then an empty symbol ends the frame.
      bus.out_ready = 1'b1;
      dv0 = dv_hi; err0 = err_cnt;
      start_frame();
      check("t1_busy", {7'b0, bus.busy}, 8'h01);
      q.push_back(8'hB4);
      send_byte(8'hB4);
      check("t1_valid_timing", {7'b0, bus.data_valid}, 8'h01);
      check("t1_data", bus.data_out, 8'hB4);
      send_symbol(4'b0000);
      wait_evt(8, gd, ge);
      check("t1_done", {7'b0, gd}, 8'h01);
      check("t1_no_err", {7'b0, ge}, 8'h00);
      @(negedge clk16);
      check("t1_busy_low", {7'b0, bus.busy}, 8'h00);
      check("t1_valid_one_cycle", 8'(dv_hi - dv0), 8'd1);
      check("t1_err_count", 8'(err_cnt - err0), 8'd0);

      // Pending byte, then a symbol with two pulses aborts and drops it.
      bus.out_ready = 1'b0;
      start_frame();
      send_byte(8'h1B);
      check("t2_pending", {7'b0, bus.data_valid}, 8'h01);
      check("t2_data", bus.data_out, 8'h1B);
      send_symbol(4'b0110);
      wait_evt(8, gd, ge);
      check("t2_err", {7'b0, ge}, 8'h01);
      check("t2_no_done", {7'b0, gd}, 8'h00);
      check("t2_valid_cleared", {7'b0, bus.data_valid}, 8'h00);
      @(negedge clk16);
      check("t2_busy_low", {7'b0, bus.busy}, 8'h00);
      check("t2_err_pulse", {7'b0, bus.frame_err}, 8'h00);

      // Overrun: 0x00 held, 0xFF completes with out_ready low.
      start_frame();
      send_byte(8'h00);
      check("t3_first_held", {7'b0, bus.data_valid}, 8'h01);
      check("t3_first_data", bus.data_out, 8'h00);
      send_byte(8'hFF);
      wait_evt(8, gd, ge);
      check("t3_overrun_err", {7'b0, ge}, 8'h01);
      check("t3_data_kept", bus.data_out, 8'h00);
      check("t3_valid_cleared", {7'b0, bus.data_valid}, 8'h00);
      @(negedge clk16);
      bus.out_ready = 1'b1;

      // Reset mid-byte discards the frame silently; next frame decodes.
      err0 = err_cnt;
      start_frame();
      q.push_back(8'h5A);
      send_byte(8'h5A);
      send_symbol(4'b0010);
      send_symbol(4'b0100);
      rst = 1'b1;
      @(negedge clk16);
      check_idle_outputs("t4_midrst");
      rst = 1'b0;
      @(negedge clk16);
      check("t4_no_err", 8'(err_cnt - err0), 8'd0);
      start_frame();
      q.push_back(8'h1B);
      send_byte(8'h1B);
      send_symbol(4'b0000);
      wait_evt(8, gd, ge);
      check("t4_done", {7'b0, gd}, 8'h01);
      @(negedge clk16);

      // Frame length limit (MAX_BYTES = 2 on this instance).
      start_frame();
      q.push_back(8'h11);
      q.push_back(8'h22);
      send_byte(8'h11);
      send_byte(8'h22);
`ifdef PPM_RX_MAXLEN_EN
      send_symbol(4'b1000);
      wait_evt(8, gd, ge);
      check("t5_maxlen_err", {7'b0, ge}, 8'h01);
      check("t5_no_done", {7'b0, gd}, 8'h00);
`else
      q.push_back(8'h33);
      send_byte(8'h33);
      send_symbol(4'b0000);
      wait_evt(8, gd, ge);
      check("t5_done", {7'b0, gd}, 8'h01);
      check("t5_no_err", {7'b0, ge}, 8'h00);
`endif
      repeat (3) @(negedge clk16);
      check("scoreboard_empty", 8'(q.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
